// File: rtl/vm_btn_pkg.sv
// Shared definitions for the vending machine button front end:
// channel count, press-code width, button index map and repeat FSM states.
package vm_btn_pkg;

  localparam int unsigned N_BTN      = 12;
  localparam int unsigned BTN_CODE_W = 4;

  // Panel button index map
  localparam int unsigned BTN_MONEY_0 = 0;
  localparam int unsigned BTN_MONEY_1 = 1;
  localparam int unsigned BTN_MONEY_2 = 2;
  localparam int unsigned BTN_ITEM_0  = 3;
  localparam int unsigned BTN_ITEM_1  = 4;
  localparam int unsigned BTN_ITEM_2  = 5;
  localparam int unsigned BTN_ITEM_3  = 6;
  localparam int unsigned BTN_ITEM_4  = 7;
  localparam int unsigned BTN_ITEM_5  = 8;
  localparam int unsigned BTN_ITEM_6  = 9;
  localparam int unsigned BTN_ITEM_7  = 10;
  localparam int unsigned BTN_CANCEL  = 11;

  // Per-channel auto-repeat state
  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_HELD  = 2'd1,
    RPT_DELAY = 2'd2,
    RPT_RATE  = 2'd3
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter debounce and the
// auto-repeat FSM. pulse_o is the combinational press/repeat event that the
// top level registers, so it coincides with the edge where level_o changes.
module btn_debounce_ch
  import vm_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 20000,
  parameter int unsigned REPEAT_DELAY_CYC = 500000,
  parameter int unsigned REPEAT_RATE_CYC  = 100000,
  parameter bit          REPEAT_EN        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);

  // Counters clear on the cycle they would reach their limit, so they never wrap.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] RAT_LAST = RPT_W'(REPEAT_RATE_CYC - 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic [DEB_W-1:0] dcnt_q, dcnt_d;
  logic [RPT_W-1:0] rcnt_q, rcnt_d;
  rpt_state_e       st_q, st_d;
  logic             pulse;

  // Debounce: count consecutive samples that disagree with the accepted level
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = '0;
    if (s2_q != lvl_q) begin
      if (dcnt_q == DEB_LAST) begin
        lvl_d = ~lvl_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // Repeat FSM: looks at the next level so a release suppresses any pulse at once
  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    pulse  = 1'b0;
    unique case (st_q)
      RPT_IDLE: begin
        if (lvl_d && !lvl_q) begin
          pulse  = 1'b1;
          rcnt_d = '0;
          st_d   = REPEAT_EN ? RPT_DELAY : RPT_HELD;
        end
      end
      RPT_HELD: begin
        if (!lvl_d) st_d = RPT_IDLE;
      end
      RPT_DELAY: begin
        if (!lvl_d) begin
          st_d   = RPT_IDLE;
          rcnt_d = '0;
        end else if (rcnt_q == DLY_LAST) begin
          pulse  = 1'b1;
          st_d   = RPT_RATE;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RPT_RATE: begin
        if (!lvl_d) begin
          st_d   = RPT_IDLE;
          rcnt_d = '0;
        end else if (rcnt_q == RAT_LAST) begin
          pulse  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        st_d   = RPT_IDLE;
        rcnt_d = '0;
      end
    endcase
  end

  // Synchroniser, debounce and repeat state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      dcnt_q <= '0;
      rcnt_q <= '0;
      st_q   <= RPT_IDLE;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      dcnt_q <= dcnt_d;
      rcnt_q <= rcnt_d;
      st_q   <= st_d;
    end
  end

  assign level_o = lvl_q;
  assign pulse_o = pulse;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: N_BTN conditioned channels plus a registered press pulse
// vector, any-press flag and lowest-index press code.
module button_conditioner
  import vm_btn_pkg::*;
#(
  parameter int unsigned       N_BTN            = vm_btn_pkg::N_BTN,
  parameter int unsigned       DEBOUNCE_CYC     = 20000,
  parameter int unsigned       REPEAT_DELAY_CYC = 500000,
  parameter int unsigned       REPEAT_RATE_CYC  = 100000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_level,
  output logic [N_BTN-1:0]      btn_pulse,
  output logic                  btn_valid,
  output logic [BTN_CODE_W-1:0] btn_code
);

  logic [N_BTN-1:0]      pulse_ev;
  logic [N_BTN-1:0]      pulse_q;
  logic                  valid_q;
  logic [BTN_CODE_W-1:0] code_q, code_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC    (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .pulse_o(pulse_ev[i])
    );
  end

  // Priority encoder: lowest pulsing index wins, 0 when nothing pulses
  always_comb begin
    code_d = '0;
    for (int unsigned i = N_BTN; i > 0; i--) begin
      if (pulse_ev[i-1]) code_d = BTN_CODE_W'(i - 1);
    end
  end

  // Output registers: pulse, valid and code all land on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      pulse_q <= pulse_ev;
      valid_q <= |pulse_ev;
      code_q  <= code_d;
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_valid = valid_q;
  assign btn_code  = code_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: timing-rule reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized bouncing inputs with occasional resets.
module tb_button_conditioner;

  localparam int NB  = 12;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int RAT = 5;
  localparam logic [NB-1:0] MASK = 12'h008;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          btn_valid;
  logic [3:0]    btn_code;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYC    (DEB),
    .REPEAT_DELAY_CYC(DLY),
    .REPEAT_RATE_CYC (RAT),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_valid(btn_valid),
    .btn_code (btn_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [NB-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = NB - 1; i >= 0; i--) if (v[i]) c = 4'(i);
    return c;
  endfunction

  // Reference model: raw is seen two edges late; a level is accepted once the
  // last DEB seen samples all disagree with it; pulses follow from the time
  // elapsed since the press edge.
  logic [NB-1:0]  m_s1 = '0, m_s2 = '0, m_level = '0, m_pulse = '0;
  logic [DEB-1:0] m_hist [NB];
  int             m_press [NB];
  int             m_edge = 0;
  bit             model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    m_edge++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
      for (int i = 0; i < NB; i++) m_hist[i] = '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        logic nl;
        int   d;
        m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
        nl = m_level[i];
        if (m_hist[i] == {DEB{~m_level[i]}}) nl = ~m_level[i];
        m_pulse[i] = 1'b0;
        if (nl && !m_level[i]) begin
          m_pulse[i] = 1'b1;
          m_press[i] = m_edge;
        end else if (nl && MASK[i]) begin
          d = m_edge - m_press[i];
          if (d == DLY || (d > DLY && (d - DLY) % RAT == 0)) m_pulse[i] = 1'b1;
        end
        m_level[i] = nl;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("level", 32'(btn_level), 32'(m_level));
      check("pulse", 32'(btn_pulse), 32'(m_pulse));
      check("valid", 32'(btn_valid), 32'(|m_pulse));
      check("code",  32'(btn_code),  32'(lowest(m_pulse)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;

  initial begin
    // Reset held with every raw input high: all outputs stay zero
    btn_raw = '1;
    rst     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_pulse", 32'(btn_pulse), 32'h0);
      check("rst_valid", 32'(btn_valid), 32'h0);
    end
    btn_raw = '0;
    step(1);
    rst = 1'b0;
    step(3);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    step(5);
    check("clean_level_before", 32'(btn_level[0]), 32'h0);
    step(1);
    check("clean_level", 32'(btn_level[0]), 32'h1);
    check("clean_pulse", 32'(btn_pulse), 32'h001);
    check("clean_valid", 32'(btn_valid), 32'h1);
    check("clean_code",  32'(btn_code),  32'h0);
    cnt = 0;
    for (int k = 0; k < 23; k++) begin step(1); cnt += int'(btn_pulse[0]); end
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin step(1); cnt += int'(btn_pulse[0]); end
    check("clean_no_extra", 32'(cnt), 32'h0);

    // Bounce on channel 1, then stable high
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1;
    step(5);
    check("bounce_early", 32'(btn_pulse), 32'h0);
    step(1);
    check("bounce_pulse", 32'(btn_pulse), 32'h002);
    check("bounce_code",  32'(btn_code),  32'h1);
    step(3);
    btn_raw[1] = 1'b0;
    step(10);

    // Auto-repeat on channel 3: press at P, repeats at P+10, P+15, P+20
    btn_raw[3] = 1'b1;
    step(6);
    check("rpt_press", 32'(btn_pulse), 32'h008);
    step(9);
    check("rpt_gap", 32'(btn_pulse), 32'h000);
    step(1);
    check("rpt_first", 32'(btn_pulse), 32'h008);
    check("rpt_code",  32'(btn_code),  32'h3);
    step(5);
    check("rpt_second", 32'(btn_pulse), 32'h008);
    step(5);
    check("rpt_third", 32'(btn_pulse), 32'h008);
    step(14);
    btn_raw[3] = 1'b0;
    step(12);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step(1); cnt += int'(btn_pulse[3]); end
    check("rpt_after_release", 32'(cnt), 32'h0);

    // Same hold on channel 4 (repeat disabled): exactly one pulse
    btn_raw[4] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(1); cnt += int'(btn_pulse[4]); end
    btn_raw[4] = 1'b0;
    for (int k = 0; k < 12; k++) begin step(1); cnt += int'(btn_pulse[4]); end
    check("norpt_count", 32'(cnt), 32'h1);

    // Simultaneous press on channels 2 and 7
    btn_raw[2] = 1'b1;
    btn_raw[7] = 1'b1;
    step(6);
    check("simul_pulse", 32'(btn_pulse), 32'h084);
    check("simul_code",  32'(btn_code),  32'h2);
    check("simul_valid", 32'(btn_valid), 32'h1);
    step(1);
    check("simul_clear", 32'(btn_pulse), 32'h000);
    btn_raw[2] = 1'b0;
    btn_raw[7] = 1'b0;
    step(12);

    // Reset in the middle of channel 5 debounce
    btn_raw[5] = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    check("midrst_level", 32'(btn_level), 32'h0);
    rst = 1'b0;
    step(5);
    check("midrst_early", 32'(btn_pulse), 32'h000);
    step(1);
    check("midrst_pulse", 32'(btn_pulse), 32'h020);
    check("midrst_code",  32'(btn_code),  32'h5);
    btn_raw[5] = 1'b0;
    step(12);

    // Randomized bouncing inputs with rare resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 99) < ((i == 3) ? 2 : 5)) btn_raw[i] = ~btn_raw[i];
      end
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
